ulpi_reg_access: RTL and testbench
==================================

// Module: ulpi_reg_access
// PURPOSE
//  ULPI register access engine for the USB3300 sniffer. Performs register write AND read,
//  immediate (6-bit) and extended (8-bit, via 0x2F escape) addressing, with NXT/DIR timeout
//  and PHY-abort detection. Sits between the ULPI controller and the ULPI pins; it owns the
//  bus only while BUSY=1.
// PARAMETERS
//  EXT_ADDR_EN  1   1: ADDR>=0x2F uses extended access; 0: only ADDR[5:0] used, ADDR[7:6] ignored
//  NXT_TIMEOUT  15  max cycles spent in any wait state before timeout error (>=2)
//  CNT_W        4   timeout counter width; must hold NXT_TIMEOUT
// PORTS
//  clk            in   1  system clock (ULPI 60 MHz domain)
//  rst            in   1  synchronous, active-high reset
//  START          in   1  request; accepted only in IDLE with DIR=0, otherwise ignored
//  RW             in   1  1=read, 0=write; latched on accept
//  ADDR           in   8  register address; latched on accept
//  WDATA          in   8  write data; latched on accept
//  BUSY           out  1  1 while state!=IDLE
//  DONE           out  1  one-cycle pulse on return to IDLE after any accepted request
//  ERR            out  2  valid with DONE: 00 ok, 01 aborted by PHY (DIR), 10 timeout
//  RDATA          out  8  read result; updated only on successful read, held otherwise
//  DIR            in   1  ULPI DIR
//  NXT            in   1  ULPI NXT
//  STP            out  1  ULPI STP
//  ULPI_DATA_IN   in   8  ULPI data from PHY
//  ULPI_DATA_OUT  out  8  ULPI data to PHY (0x00 when not driving)
//  ULPI_OE        out  1  1 = link drives ULPI data bus
// BEHAVIOUR
//  - All outputs registered. Reset: state IDLE, BUSY=0, DONE=0, ERR=00, RDATA=0x00,
//    STP=0, ULPI_DATA_OUT=0x00, ULPI_OE=0, counter=0. rst mid-operation: same values next
//    cycle, no DONE pulse, bus released immediately.
//  - ext = EXT_ADDR_EN && ADDR>=0x2F. TXCMD = {RW?2'b11:2'b10, ext?6'h2F:ADDR[5:0]}.
//  - States / transitions (counter clears on every state change):
//    IDLE:  START&&!DIR -> TXCMD; drive TXCMD, OE=1.
//    TXCMD: DIR -> ABORT. NXT: ext -> EXTADDR (drive ADDR); write -> WR (drive WDATA);
//           read -> TURN1 (OE=0, DATA_OUT=0).
//    EXTADDR: DIR -> ABORT. NXT: write -> WR (drive WDATA); read -> TURN1 (OE=0).
//    WR:    DIR -> ABORT. NXT -> STP (STP=1, DATA_OUT=0x00, OE stays 1).
//    STP:   one cycle; -> IDLE, STP=0, OE=0, DONE=1 with recorded ERR.
//    TURN1: wait DIR=1 -> RD.
//    RD:    NXT=0: RDATA<=ULPI_DATA_IN, ERR ok. NXT=1 (RX cmd/packet): ERR=01. -> TURN2.
//    TURN2: wait DIR=0 -> IDLE, DONE=1.
//    ABORT: OE=0, DATA_OUT=0 in same cycle DIR sampled high; ERR=01; -> TURN2.
//  - DIR has priority over NXT in every link-driving state.
//  - Timeout: counter increments each cycle in TXCMD/EXTADDR/WR/TURN1/TURN2; reaching
//    NXT_TIMEOUT sets ERR=10 and: link-driving states -> STP (STP pulse ends transfer);
//    TURN1 -> IDLE with DONE; TURN2 -> IDLE with DONE (DIR still high, bus not taken).
//  - START while BUSY or DONE cycle: ignored. New START accepted in the DONE cycle's IDLE.
//  - Latency (NXT immediate): write imm 4 cycles START->DONE, write ext 5, read imm =
//    TXCMD+NXT, turnaround, data, turnaround -> DONE 5 cycles after START.
// TESTING
//  1. Write imm ADDR=0x04 WDATA=0x45, NXT high each driven cycle -> DATA_OUT 0x84,0x45,
//     STP=1 with 0x00, then DONE=1 ERR=00; 4 cycles START->DONE.
//  2. Write ext ADDR=0x3A WDATA=0xA5 -> DATA_OUT 0xAF,0x3A,0xA5, STP, DONE ERR=00;
//     repeat with EXT_ADDR_EN=0 -> 0xBA,0xA5 only.
//  3. Read imm ADDR=0x0A, PHY: NXT on TXCMD, DIR=1 next, 0x5C next with NXT=0, DIR=0
//     -> OE drops after NXT, RDATA=0x5C, DONE ERR=00.
//  4. DIR rises while TXCMD 0x84 driven (no NXT) -> OE=0 same cycle, DONE ERR=01 once
//     DIR falls; RDATA unchanged; no STP.
//  5. Write with NXT never asserted -> after 15 cycles STP pulse, DONE ERR=10; read with
//     DIR stuck high in RD/TURN2 -> DONE ERR=10.
//  6. Assert rst in WR state -> next cycle OE=0 STP=0 BUSY=0 DONE=0; START with DIR=1
//     in IDLE -> ignored, BUSY stays 0.

Source files
------------

// File: rtl/ulpi_reg_access_if.sv
// rtl/ulpi_reg_access_if.sv - request/response and ULPI pin bundle for ulpi_reg_access
//
// Purpose: groups the controller-side request/response signals and the ULPI pins
//          seen by the register access engine.
// Ports (signals):
//   START, RW, ADDR[7:0], WDATA[7:0]   request from the ULPI controller
//   BUSY, DONE, ERR[1:0], RDATA[7:0]   status/result back to the controller
//   DIR, NXT, ULPI_DATA_IN[7:0]        ULPI pins driven by the PHY
//   STP, ULPI_DATA_OUT[7:0], ULPI_OE   ULPI pins driven by the link
// Modports:
//   slave  - the register access engine
//   master - controller + PHY side (the environment)
interface ulpi_reg_access_if;
    logic       START;
    logic       RW;
    logic [7:0] ADDR;
    logic [7:0] WDATA;
    logic       BUSY;
    logic       DONE;
    logic [1:0] ERR;
    logic [7:0] RDATA;
    logic       DIR;
    logic       NXT;
    logic       STP;
    logic [7:0] ULPI_DATA_IN;
    logic [7:0] ULPI_DATA_OUT;
    logic       ULPI_OE;

    modport slave (
        input  START, RW, ADDR, WDATA, DIR, NXT, ULPI_DATA_IN,
        output BUSY, DONE, ERR, RDATA, STP, ULPI_DATA_OUT, ULPI_OE
    );

    modport master (
        output START, RW, ADDR, WDATA, DIR, NXT, ULPI_DATA_IN,
        input  BUSY, DONE, ERR, RDATA, STP, ULPI_DATA_OUT, ULPI_OE
    );
endinterface

// File: rtl/ulpi_reg_access.sv
// rtl/ulpi_reg_access.sv - ULPI register read/write engine with extended addressing
//
// Purpose: issues ULPI register write/read transactions (immediate or 0x2F-escaped
//          extended address), with NXT/DIR wait timeouts and PHY abort detection.
//          Owns the ULPI bus only while BUSY is high.
// Ports:
//   clk  - ULPI 60 MHz clock
//   rst  - synchronous active-high reset
//   bus  - ulpi_reg_access_if.slave: request/status and ULPI pins
// All outputs are registered; output values are decoded from the next state.
module ulpi_reg_access #(
    parameter int EXT_ADDR_EN = 1,
    parameter int NXT_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input logic              clk,
    input logic              rst,
    ulpi_reg_access_if.slave bus
);
    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_TXCMD   = 4'd1;
    localparam logic [3:0] S_EXTADDR = 4'd2;
    localparam logic [3:0] S_WR      = 4'd3;
    localparam logic [3:0] S_STP     = 4'd4;
    localparam logic [3:0] S_TURN1   = 4'd5;
    localparam logic [3:0] S_RD      = 4'd6;
    localparam logic [3:0] S_TURN2   = 4'd7;
    localparam logic [3:0] S_ABORT   = 4'd8;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_ABORT = 2'b01;
    localparam logic [1:0] ERR_TMO   = 2'b10;

    // Counter holds the number of completed cycles already spent in the state,
    // so the timeout fires at the end of the NXT_TIMEOUT-th cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NXT_TIMEOUT - 1);

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rw_q, rw_d;
    logic             ext_q, ext_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [1:0]       err_q, err_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             stp_q, stp_d;
    logic             oe_q, oe_d;
    logic [7:0]       dout_q, dout_d;
    logic             timeout;
    logic [7:0]       txcmd;

    assign timeout = (cnt_q == CNT_LAST);

    // Uses the next-cycle request fields so the TX command is on the bus the
    // cycle right after START is accepted.
    assign txcmd = {(rw_d ? 2'b11 : 2'b10), (ext_d ? 6'h2F : addr_d[5:0])};

    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        ext_d   = ext_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        cnt_d   = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.START && !bus.DIR) begin
                    rw_d    = bus.RW;
                    addr_d  = bus.ADDR;
                    wdata_d = bus.WDATA;
                    ext_d   = (EXT_ADDR_EN != 0) && (bus.ADDR >= 8'h2F);
                    err_d   = ERR_OK;
                    state_d = S_TXCMD;
                end
            end
            // DIR wins over NXT: the PHY has taken the bus.
            S_TXCMD: begin
                if (bus.DIR) begin
                    err_d   = ERR_ABORT;
                    state_d = S_ABORT;
                end else if (bus.NXT) begin
                    state_d = ext_q ? S_EXTADDR : (rw_q ? S_TURN1 : S_WR);
                end else if (timeout) begin
                    err_d   = ERR_TMO;
                    state_d = S_STP;
                end
            end
            S_EXTADDR: begin
                if (bus.DIR) begin
                    err_d   = ERR_ABORT;
                    state_d = S_ABORT;
                end else if (bus.NXT) begin
                    state_d = rw_q ? S_TURN1 : S_WR;
                end else if (timeout) begin
                    err_d   = ERR_TMO;
                    state_d = S_STP;
                end
            end
            S_WR: begin
                if (bus.DIR) begin
                    err_d   = ERR_ABORT;
                    state_d = S_ABORT;
                end else if (bus.NXT) begin
                    state_d = S_STP;
                end else if (timeout) begin
                    err_d   = ERR_TMO;
                    state_d = S_STP;
                end
            end
            S_STP: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_TURN1: begin
                if (bus.DIR) begin
                    state_d = S_RD;
                end else if (timeout) begin
                    err_d   = ERR_TMO;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            // NXT high here means the PHY is returning an RX command instead
            // of register data, so the read is treated as aborted.
            S_RD: begin
                if (!bus.NXT) begin
                    rdata_d = bus.ULPI_DATA_IN;
                    err_d   = ERR_OK;
                end else begin
                    err_d   = ERR_ABORT;
                end
                state_d = S_TURN2;
            end
            S_TURN2: begin
                if (!bus.DIR) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (timeout) begin
                    err_d   = ERR_TMO;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_ABORT: begin
                state_d = S_TURN2;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if ((state_d == state_q) &&
            (state_q inside {S_TXCMD, S_EXTADDR, S_WR, S_TURN1, S_TURN2})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        oe_d   = 1'b0;
        dout_d = 8'h00;
        stp_d  = 1'b0;
        busy_d = (state_d != S_IDLE);
        case (state_d)
            S_TXCMD: begin
                oe_d   = 1'b1;
                dout_d = txcmd;
            end
            S_EXTADDR: begin
                oe_d   = 1'b1;
                dout_d = addr_d;
            end
            S_WR: begin
                oe_d   = 1'b1;
                dout_d = wdata_d;
            end
            S_STP: begin
                oe_d  = 1'b1;
                stp_d = 1'b1;
            end
            default: begin
                oe_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            ext_q   <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            err_q   <= ERR_OK;
            rdata_q <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            stp_q   <= 1'b0;
            oe_q    <= 1'b0;
            dout_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            ext_q   <= ext_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            stp_q   <= stp_d;
            oe_q    <= oe_d;
            dout_q  <= dout_d;
        end
    end

    assign bus.BUSY          = busy_q;
    assign bus.DONE          = done_q;
    assign bus.ERR           = err_q;
    assign bus.RDATA         = rdata_q;
    assign bus.STP           = stp_q;
    assign bus.ULPI_DATA_OUT = dout_q;
    assign bus.ULPI_OE       = oe_q;
endmodule

// File: tb/tb_ulpi_reg_access.sv
// tb/tb_ulpi_reg_access.sv - self-checking bench for ulpi_reg_access
module tb_ulpi_reg_access;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ulpi_reg_access_if if0 ();
    ulpi_reg_access_if if1 ();

    ulpi_reg_access #(.EXT_ADDR_EN(1), .NXT_TIMEOUT(15), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .bus(if0.slave)
    );
    ulpi_reg_access #(.EXT_ADDR_EN(0), .NXT_TIMEOUT(15), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .bus(if1.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    int start_cyc = 0;
    logic cmp_en = 1'b0;
    logic sel = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc_cnt++;

    // Reference model: a transfer is a list of bytes the link must put on the
    // bus, each consumed by one NXT; then stop (write) or turnaround/capture (read).
    localparam int TMO = 15;
    localparam int P_IDLE = 0, P_DRIVE = 1, P_STOP = 2, P_TURN_IN = 3;
    localparam int P_CAPTURE = 4, P_TURN_OUT = 5, P_ABORT = 6;
    int         m_phase = P_IDLE;
    logic [7:0] m_beat[3];
    int         m_nbeat = 0, m_pos = 0, m_wait = 0;
    logic       m_rd = 1'b0, m_ext = 1'b0, m_done = 1'b0;
    logic [1:0] m_err = 2'b00;
    logic [7:0] m_rdata = 8'h00;

    always @(posedge clk) begin
        m_done = 1'b0;
        if (rst) begin
            m_phase = P_IDLE; m_err = 2'b00; m_rdata = 8'h00; m_wait = 0; m_pos = 0;
        end else begin
            case (m_phase)
                P_IDLE: if (if0.START && !if0.DIR) begin
                    m_ext = (if0.ADDR >= 8'h2F);
                    m_beat[0] = {(if0.RW ? 2'b11 : 2'b10), (m_ext ? 6'h2F : if0.ADDR[5:0])};
                    m_nbeat = 1;
                    if (m_ext) begin m_beat[m_nbeat] = if0.ADDR; m_nbeat++; end
                    if (!if0.RW) begin m_beat[m_nbeat] = if0.WDATA; m_nbeat++; end
                    m_rd = if0.RW; m_pos = 0; m_wait = 0; m_err = 2'b00; m_phase = P_DRIVE;
                end
                P_DRIVE: begin
                    if (if0.DIR) begin
                        m_err = 2'b01; m_phase = P_ABORT;
                    end else if (if0.NXT) begin
                        m_pos++; m_wait = 0;
                        if (m_pos == m_nbeat) m_phase = m_rd ? P_TURN_IN : P_STOP;
                    end else begin
                        m_wait++;
                        if (m_wait == TMO) begin m_err = 2'b10; m_phase = P_STOP; end
                    end
                end
                P_STOP: begin m_phase = P_IDLE; m_done = 1'b1; end
                P_TURN_IN: begin
                    if (if0.DIR) begin
                        m_phase = P_CAPTURE; m_wait = 0;
                    end else begin
                        m_wait++;
                        if (m_wait == TMO) begin m_err = 2'b10; m_phase = P_IDLE; m_done = 1'b1; end
                    end
                end
                P_CAPTURE: begin
                    if (!if0.NXT) begin m_rdata = if0.ULPI_DATA_IN; m_err = 2'b00; end
                    else m_err = 2'b01;
                    m_phase = P_TURN_OUT; m_wait = 0;
                end
                P_TURN_OUT: begin
                    if (!if0.DIR) begin
                        m_phase = P_IDLE; m_done = 1'b1;
                    end else begin
                        m_wait++;
                        if (m_wait == TMO) begin m_err = 2'b10; m_phase = P_IDLE; m_done = 1'b1; end
                    end
                end
                P_ABORT: begin m_phase = P_TURN_OUT; m_wait = 0; end
                default: m_phase = P_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("BUSY", 32'(if0.BUSY), 32'(m_phase != P_IDLE));
            chk("ULPI_OE", 32'(if0.ULPI_OE), 32'(m_phase == P_DRIVE || m_phase == P_STOP));
            chk("ULPI_DATA_OUT", 32'(if0.ULPI_DATA_OUT),
                32'((m_phase == P_DRIVE && m_pos < 3) ? m_beat[m_pos] : 8'h00));
            chk("STP", 32'(if0.STP), 32'(m_phase == P_STOP));
            chk("DONE", 32'(if0.DONE), 32'(m_done));
            if (m_done) chk("ERR", 32'(if0.ERR), 32'(m_err));
            chk("RDATA", 32'(if0.RDATA), 32'(m_rdata));
        end
    end

    // Transaction log used by the literal expectations.
    logic [7:0] log0[$];
    logic [7:0] log1[$];
    int stp0 = 0, stp1 = 0, done0 = 0, done1 = 0, done_cyc0 = 0, done_cyc1 = 0;
    logic [1:0] done_err0 = 2'b00, done_err1 = 2'b00;

    always @(negedge clk) begin
        if (if0.ULPI_OE === 1'b1) log0.push_back(if0.ULPI_DATA_OUT);
        if (if0.STP === 1'b1) stp0++;
        if (if0.DONE === 1'b1) begin done0++; done_cyc0 = cyc_cnt; done_err0 = if0.ERR; end
        if (if1.ULPI_OE === 1'b1) log1.push_back(if1.ULPI_DATA_OUT);
        if (if1.STP === 1'b1) stp1++;
        if (if1.DONE === 1'b1) begin done1++; done_cyc1 = cyc_cnt; done_err1 = if1.ERR; end
    end

    task automatic cyc(input logic st, input logic dir, input logic nxt, input logic [7:0] din);
        if (!sel) begin
            if0.START = st; if0.DIR = dir; if0.NXT = nxt; if0.ULPI_DATA_IN = din;
            if1.START = 1'b0; if1.DIR = 1'b0; if1.NXT = 1'b0; if1.ULPI_DATA_IN = 8'h00;
        end else begin
            if1.START = st; if1.DIR = dir; if1.NXT = nxt; if1.ULPI_DATA_IN = din;
            if0.START = 1'b0; if0.DIR = 1'b0; if0.NXT = 1'b0; if0.ULPI_DATA_IN = 8'h00;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic req(input logic rw, input logic [7:0] addr, input logic [7:0] wdata);
        if0.RW = rw; if0.ADDR = addr; if0.WDATA = wdata;
        if1.RW = rw; if1.ADDR = addr; if1.WDATA = wdata;
    endtask

    task automatic clr;
        log0.delete(); log1.delete();
        stp0 = 0; stp1 = 0; done0 = 0; done1 = 0;
        start_cyc = cyc_cnt;
    endtask

    task automatic chk_log(input string name, input bit which, input int n,
                           input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] e[4];
        int sz;
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        sz = which ? log1.size() : log0.size();
        chk({name, "_len"}, 32'(sz), 32'(n));
        for (int i = 0; i < n && i < sz; i++)
            chk({name, "_byte"}, 32'(which ? log1[i] : log0[i]), 32'(e[i]));
    endtask

    task automatic chk_txn(input string name, input bit which, input int lat,
                           input logic [1:0] err, input int nstp);
        int l;
        l = (which ? done_cyc1 : done_cyc0) - start_cyc;
        chk({name, "_done_cnt"}, 32'(which ? done1 : done0), 32'd1);
        chk({name, "_latency"}, 32'(l), 32'(lat));
        chk({name, "_err"}, 32'(which ? done_err1 : done_err0), 32'(err));
        chk({name, "_stp_cnt"}, 32'(which ? stp1 : stp0), 32'(nstp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req(1'b0, 8'h00, 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        cmp_en = 1'b1;
        idle(2);
        chk("rst_busy", 32'(if0.BUSY), 32'd0);
        chk("rst_oe", 32'(if0.ULPI_OE), 32'd0);
        chk("rst_dout", 32'(if0.ULPI_DATA_OUT), 32'h00);
        chk("rst_rdata", 32'(if0.RDATA), 32'h00);
        chk("rst_err", 32'(if0.ERR), 32'd0);
        rst = 1'b0;
        idle(2);

        // Immediate write
        req(1'b0, 8'h04, 8'h45); clr;
        cyc(1'b1, 1'b0, 1'b1, 8'h00);
        repeat (2) cyc(1'b0, 1'b0, 1'b1, 8'h00);
        idle(4);
        chk_log("wr_imm", 1'b0, 3, 8'h84, 8'h45, 8'h00, 8'h00);
        chk_txn("wr_imm", 1'b0, 4, 2'b00, 1);

        // Extended write
        req(1'b0, 8'h3A, 8'hA5); clr;
        cyc(1'b1, 1'b0, 1'b1, 8'h00);
        repeat (3) cyc(1'b0, 1'b0, 1'b1, 8'h00);
        idle(4);
        chk_log("wr_ext", 1'b0, 4, 8'hAF, 8'h3A, 8'hA5, 8'h00);
        chk_txn("wr_ext", 1'b0, 5, 2'b00, 1);

        // Same address with extended addressing disabled
        sel = 1'b1; clr;
        cyc(1'b1, 1'b0, 1'b1, 8'h00);
        repeat (2) cyc(1'b0, 1'b0, 1'b1, 8'h00);
        idle(4);
        chk_log("wr_noext", 1'b1, 3, 8'hBA, 8'hA5, 8'h00, 8'h00);
        chk_txn("wr_noext", 1'b1, 4, 2'b00, 1);
        sel = 1'b0;

        // Immediate read
        req(1'b1, 8'h0A, 8'h00); clr;
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 8'h5C);
        idle(4);
        chk_log("rd_imm", 1'b0, 1, 8'hCA, 8'h00, 8'h00, 8'h00);
        chk_txn("rd_imm", 1'b0, 5, 2'b00, 0);
        chk("rd_imm_rdata", 32'(if0.RDATA), 32'h5C);

        // Extended read
        req(1'b1, 8'h30, 8'h00); clr;
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        repeat (2) cyc(1'b0, 1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 8'h77);
        idle(4);
        chk_log("rd_ext", 1'b0, 2, 8'hEF, 8'h30, 8'h00, 8'h00);
        chk_txn("rd_ext", 1'b0, 6, 2'b00, 0);
        chk("rd_ext_rdata", 32'(if0.RDATA), 32'h77);

        // PHY takes the bus during TXCMD
        req(1'b0, 8'h04, 8'h45); clr;
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        chk("abort_oe_drop", 32'(if0.ULPI_OE), 32'd0);
        repeat (2) cyc(1'b0, 1'b1, 1'b0, 8'h00);
        idle(4);
        chk_log("abort", 1'b0, 1, 8'h84, 8'h00, 8'h00, 8'h00);
        chk_txn("abort", 1'b0, 5, 2'b01, 0);
        chk("abort_rdata", 32'(if0.RDATA), 32'h77);

        // DIR and NXT together: DIR wins
        clr;
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 1'b1, 8'h00);
        idle(4);
        chk_txn("dir_prio", 1'b0, 4, 2'b01, 0);

        // Write timeout, NXT never asserted
        clr;
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        idle(22);
        chk("wr_tmo_len", 32'(log0.size()), 32'd16);
        chk_txn("wr_tmo", 1'b0, 17, 2'b10, 1);

        // NXT on the last allowed cycle still completes normally
        clr;
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        idle(14);
        repeat (2) cyc(1'b0, 1'b0, 1'b1, 8'h00);
        idle(4);
        chk("nxt_last_len", 32'(log0.size()), 32'd17);
        chk_txn("nxt_last", 1'b0, 18, 2'b00, 1);

        // Read with DIR stuck high after an RX command in place of data
        req(1'b1, 8'h0A, 8'h00); clr;
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b1, 1'b1, 8'h00);
        cyc(1'b0, 1'b1, 1'b1, 8'h99);
        repeat (20) cyc(1'b0, 1'b1, 1'b0, 8'h00);
        idle(3);
        chk_txn("turn2_tmo", 1'b0, 19, 2'b10, 0);
        chk("turn2_tmo_rdata", 32'(if0.RDATA), 32'h77);

        // Read where the PHY never turns the bus around
        clr;
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        idle(20);
        chk_txn("turn1_tmo", 1'b0, 17, 2'b10, 0);

        // Reset while in WR
        req(1'b0, 8'h04, 8'h45); clr;
        cyc(1'b1, 1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        chk("rst_wr_oe", 32'(if0.ULPI_OE), 32'd0);
        chk("rst_wr_stp", 32'(if0.STP), 32'd0);
        chk("rst_wr_busy", 32'(if0.BUSY), 32'd0);
        chk("rst_wr_done", 32'(if0.DONE), 32'd0);
        rst = 1'b0;
        idle(4);
        chk("rst_wr_no_done", 32'(done0), 32'd0);

        // START with DIR high in IDLE is ignored
        clr;
        cyc(1'b1, 1'b1, 1'b0, 8'h00);
        chk("start_dir_busy", 32'(if0.BUSY), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        idle(3);
        chk("start_dir_done", 32'(done0), 32'd0);
        chk("start_dir_len", 32'(log0.size()), 32'd0);

        // START while busy is ignored
        clr;
        cyc(1'b1, 1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        cyc(1'b1, 1'b0, 1'b1, 8'h00);
        idle(5);
        chk_log("start_busy", 1'b0, 3, 8'h84, 8'h45, 8'h00, 8'h00);
        chk_txn("start_busy", 1'b0, 4, 2'b00, 1);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
